// File: rtl/prime_seq_checker.sv
// rtl/prime_seq_checker.sv - lock-and-check monitor for the 2,3,5,7,11,13 prime counter sequence
// Define PRIME_CHK_RESYNC_EN to let FAULT re-acquire; otherwise FAULT is sticky until reset.
module prime_seq_checker #(
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       count_in,
  input  logic             valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             fault,
  output logic [3:0]       expected,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED, FAULT} state_t;

  localparam logic [2:0]       LOCK_LAST = 3'(LOCK_CNT - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;

  state_t           state, state_nx;
  logic [2:0]       mcnt, mcnt_nx;
  logic [3:0]       exp_nx;
  logic [ERR_W-1:0] err_nx;
  logic             locked_nx, pulse_nx, fault_nx;
  logic             match, prime;

  function automatic logic [3:0] nxt(input logic [3:0] v);
    case (v)
      4'd2:    nxt = 4'd3;
      4'd3:    nxt = 4'd5;
      4'd5:    nxt = 4'd7;
      4'd7:    nxt = 4'd11;
      4'd11:   nxt = 4'd13;
      default: nxt = 4'd2;
    endcase
  endfunction

  function automatic logic is_prime(input logic [3:0] v);
    is_prime = (v == 4'd2) || (v == 4'd3) || (v == 4'd5) ||
               (v == 4'd7) || (v == 4'd11) || (v == 4'd13);
  endfunction

  assign match = (count_in == expected);
  assign prime = is_prime(count_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SEARCH;
      mcnt      <= 3'd0;
      expected  <= 4'd2;
      err_cnt   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nx;
      mcnt      <= mcnt_nx;
      expected  <= exp_nx;
      err_cnt   <= err_nx;
      locked    <= locked_nx;
      err_pulse <= pulse_nx;
      fault     <= fault_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (valid) begin
      case (state)
        SEARCH:  if (prime) state_nx = ACQUIRE;
        ACQUIRE: begin
          if (match) begin
            if (mcnt == LOCK_LAST) state_nx = LOCKED;
          end else if (!prime) begin
            state_nx = SEARCH;
          end
        end
        LOCKED:  if (!match) state_nx = FAULT;
        default: begin
`ifdef PRIME_CHK_RESYNC_EN
          if (prime) state_nx = ACQUIRE;
`else
          state_nx = FAULT;
`endif
        end
      endcase
    end
  end

  always_comb begin
    mcnt_nx  = mcnt;
    exp_nx   = expected;
    err_nx   = err_cnt;
    pulse_nx = 1'b0;
    if (valid) begin
      case (state)
        SEARCH: begin
          if (prime) begin
            exp_nx  = nxt(count_in);
            mcnt_nx = 3'd0;
          end
        end
        ACQUIRE: begin
          if (match) begin
            exp_nx  = nxt(expected);
            mcnt_nx = (mcnt == LOCK_LAST) ? 3'd0 : mcnt + 3'd1;
          end else if (prime) begin
            exp_nx  = nxt(count_in);
            mcnt_nx = 3'd0;
          end else begin
            exp_nx  = 4'd2;
            mcnt_nx = 3'd0;
          end
        end
        LOCKED: begin
          if (match) begin
            exp_nx = nxt(expected);
          end else begin
            pulse_nx = 1'b1;
            if (err_cnt != ERR_MAX) err_nx = err_cnt + 1'b1;
          end
        end
        default: begin
`ifdef PRIME_CHK_RESYNC_EN
          if (prime) begin
            exp_nx  = nxt(count_in);
            mcnt_nx = 3'd0;
          end
`endif
        end
      endcase
    end
    locked_nx = (state_nx == LOCKED);
    // fault survives the SEARCH/ACQUIRE detour of a resync and clears only on relock
    if (state_nx == FAULT)       fault_nx = 1'b1;
    else if (state_nx == LOCKED) fault_nx = 1'b0;
    else                         fault_nx = fault;
  end

endmodule
